uart_tx_arbiter: RTL and testbench

- Shares one serial UART transmitter between two byte requesters, e.g. two RV32IM cores or a core plus a debug source.
- Each requester pushes bytes with a one-cycle valid strobe into its own small FIFO.
- A round-robin arbiter picks the next byte, and an 8N1 serializer drives the tx line.
- A 9-bit monitor output {valid, byte} lets the simulation UART character printer echo every byte as its frame starts.

---
 rtl/uart_tx_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin byte arbiter driving one 8N1 UART transmitter

// Per-requester byte queue with a saturating drop counter and a registered full flag
module uart_tx_arbiter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       empty_o,
  output logic       full_o,
  output logic [7:0] drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic [7:0]    drop_q, drop_d;
  logic          accept;
  logic          pop_ok;

  // Fullness is judged on the pre-edge count, so a pop in the same cycle never rescues a push
  always_comb begin
    accept  = push_i && (count_q != FULL_CNT);
    pop_ok  = pop_i && (count_q != '0);
    wptr_d  = accept ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW+1)'(accept) - (AW+1)'(pop_ok);
    full_d  = (count_d == FULL_CNT);
    drop_d  = drop_q;
    if (push_i && !accept && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Pointer, count, flag and drop-counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign drop_o  = drop_q;
endmodule

// Two byte queues, a round-robin pick in IDLE, and an 8N1 serializer with registered outputs
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       full0,
  output logic       full1,
  output logic [7:0] drop0,
  output logic [7:0] drop1,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic [8:0] mon_out
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [8:0]    mon_q, mon_d;

  logic          empty0, empty1;
  logic [7:0]    head0, head1;
  logic          pop0, pop1;
  logic          winner;
  logic [7:0]    win_byte;

  uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clock   (clock),
    .reset   (reset),
    .push_i  (req0_valid),
    .data_i  (req0_data),
    .pop_i   (pop0),
    .rdata_o (head0),
    .empty_o (empty0),
    .full_o  (full0),
    .drop_o  (drop0)
  );

  uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clock   (clock),
    .reset   (reset),
    .push_i  (req1_valid),
    .data_i  (req1_data),
    .pop_i   (pop1),
    .rdata_o (head1),
    .empty_o (empty1),
    .full_o  (full1),
    .drop_o  (drop1)
  );

  // Round-robin pick: on a tie the requester that did not go last wins; pops only happen in IDLE
  always_comb begin
    if (!empty0 && !empty1) begin
      winner = ~last_q;
    end else begin
      winner = empty0;
    end
    win_byte = winner ? head1 : head0;
    pop0     = (state_q == ST_IDLE) && !empty0 && !winner;
    pop1     = (state_q == ST_IDLE) && !empty1 && winner;
  end

  // Frame sequencer: next state plus next values of every registered output
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    last_d  = last_q;
    mon_d   = 9'd0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (pop0 || pop1) begin
          state_d = ST_START;
          baud_d  = '0;
          shift_d = win_byte;
          grant_d = winner;
          last_d  = winner;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          mon_d   = {1'b1, win_byte};
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          state_d = ST_IDLE;
          baud_d  = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers; reset forces the line idle immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      mon_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      mon_q   <= mon_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign mon_out  = mon_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized and directed bench for uart_tx_arbiter against a queue-level model
module tb_uart_tx_arbiter;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data  = 8'd0;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data  = 8'd0;
  logic       full0, full1, tx, busy, grant_id;
  logic [7:0] drop0, drop1;
  logic [8:0] mon_out;

  int n_tests  = 0;
  int n_failed = 0;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .full0      (full0),
    .full1      (full1),
    .drop0      (drop0),
    .drop1      (drop1),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id),
    .mon_out    (mon_out)
  );

  always #5 clock = ~clock;

  // reference model: queue contents, frame age in cycles, arbitration memory
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         ft;
  logic [7:0] fbyte;
  bit         m_last, m_grant;
  int         m_drop0, m_drop1;
  logic [8:0] m_mon;

  int         cyc;
  int         busy_seen;
  logic [8:0] mon_log[$];
  int         mon_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    ft      = -1;
    fbyte   = 8'd0;
    m_last  = 1'b1;
    m_grant = 1'b0;
    m_drop0 = 0;
    m_drop1 = 0;
    m_mon   = 9'd0;
  endtask

  // one clock edge of behaviour, using the state that held before the edge
  task automatic model_step(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
    bit f0, f1, g;
    f0 = (q0.size() == DEPTH);
    f1 = (q1.size() == DEPTH);
    m_mon = 9'd0;
    if (ft < 0) begin
      if (q0.size() > 0 || q1.size() > 0) begin
        if (q0.size() > 0 && q1.size() > 0) g = !m_last;
        else g = (q0.size() == 0);
        if (g) fbyte = q1.pop_front();
        else fbyte = q0.pop_front();
        m_last  = g;
        m_grant = g;
        ft      = 0;
        m_mon   = {1'b1, fbyte};
      end
    end else if (ft == FRAME - 1) begin
      ft = -1;
    end else begin
      ft++;
    end
    if (v0) begin
      if (f0) begin
        if (m_drop0 < 255) m_drop0++;
      end else q0.push_back(d0);
    end
    if (v1) begin
      if (f1) begin
        if (m_drop1 < 255) m_drop1++;
      end else q1.push_back(d1);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (ft < 0) return 1'b1;
    b = ft / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return fbyte[b-1];
  endfunction

  task automatic check_outputs();
    check_eq("tx", 32'(tx), 32'(exp_tx()));
    check_eq("busy", 32'(busy), 32'(ft >= 0));
    check_eq("mon_out", 32'(mon_out), 32'(m_mon));
    check_eq("grant_id", 32'(grant_id), 32'(m_grant));
    check_eq("full0", 32'(full0), 32'(q0.size() == DEPTH));
    check_eq("full1", 32'(full1), 32'(q1.size() == DEPTH));
    check_eq("drop0", 32'(drop0), 32'(m_drop0));
    check_eq("drop1", 32'(drop1), 32'(m_drop1));
  endtask

  // called at a negedge: drive, take the edge, then compare at the next negedge
  task automatic cycle(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    @(posedge clock);
    model_step(v0, d0, v1, d1);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc++;
    check_outputs();
    if (busy) busy_seen++;
    if (mon_out[8]) begin
      mon_log.push_back(mon_out);
      mon_cyc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    check_outputs();
    reset = 1'b0;
    busy_seen = 0;
    mon_log.delete();
    mon_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    model_reset();
    @(negedge clock);
    do_reset();

    // single byte 0x41 from requester 0
    cycle(1'b1, 8'h41, 1'b0, 8'd0);
    idle(50);
    check_eq("t1_busy_cycles", 32'(busy_seen), 32'd40);
    check_eq("t1_frames", 32'(mon_log.size()), 32'd1);
    check_eq("t1_mon", 32'(mon_log[0]), 32'h141);

    // simultaneous pushes: requester 0 first, starts 41 cycles apart
    do_reset();
    cycle(1'b1, 8'h30, 1'b1, 8'h31);
    idle(90);
    check_eq("t2_frames", 32'(mon_log.size()), 32'd2);
    check_eq("t2_first", 32'(mon_log[0]), 32'h130);
    check_eq("t2_second", 32'(mon_log[1]), 32'h131);
    check_eq("t2_spacing", 32'(mon_cyc[1] - mon_cyc[0]), 32'd41);

    // overflow: six pushes, fifth fills, sixth dropped
    do_reset();
    for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), 1'b0, 8'd0);
    check_eq("t3_drop0", 32'(drop0), 32'd1);
    idle(5 * (FRAME + 1) + 10);
    check_eq("t3_frames", 32'(mon_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) check_eq("t3_order", 32'(mon_log[i]), 32'h101 + 32'(i));

    // fairness: interleaved requesters
    do_reset();
    cycle(1'b1, 8'hA0, 1'b1, 8'hB0);
    cycle(1'b1, 8'hA1, 1'b1, 8'hB1);
    cycle(1'b1, 8'hA2, 1'b1, 8'hB2);
    idle(6 * (FRAME + 1) + 10);
    check_eq("t4_frames", 32'(mon_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check_eq("t4_order", 32'(mon_log[i]), (i % 2 == 0) ? 32'h1A0 + 32'(i / 2) : 32'h1B0 + 32'(i / 2));

    // reset during DATA bit 3
    do_reset();
    cycle(1'b1, 8'hA5, 1'b0, 8'd0);
    cycle(1'b0, 8'd0, 1'b1, 8'h5A);
    idle(16);
    reset = 1'b1;
    #1;
    check_eq("t5_tx_async", 32'(tx), 32'd1);
    check_eq("t5_busy_async", 32'(busy), 32'd0);
    check_eq("t5_mon_async", 32'(mon_out), 32'd0);
    model_reset();
    @(negedge clock);
    check_outputs();
    reset = 1'b0;
    busy_seen = 0;
    idle(60);
    check_eq("t5_no_frame", 32'(busy_seen), 32'd0);
    check_eq("t5_drop0", 32'(drop0), 32'd0);
    check_eq("t5_drop1", 32'(drop1), 32'd0);

    // drop saturation on requester 1
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b0, 8'd0, 1'b1, 8'($urandom));
    check_eq("t6_drop1_sat", 32'(drop1), 32'd255);
    check_eq("t6_full1_held", 32'(full1), 32'd1);
    idle(5 * (FRAME + 1) + 10);
    check_eq("t6_full1_drained", 32'(full1), 32'd0);
    check_eq("t6_drop1_kept", 32'(drop1), 32'd255);

    // random traffic, dense then sparse
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) == 0, 8'($urandom));
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 40) == 0, 8'($urandom), $urandom_range(0, 60) == 0, 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule
